reset_seq: RTL

Parametrised reset sequencer for the FPGA top level. It replaces the fixed 8-bit pushbutton/PLL-lock reset stretcher with a block that synchronises and debounces its asynchronous sources and releases NUM_OUT active-low resets in a fixed order with programmable spacing. It also supports a partial system reset from the core's SYSRESETREQ and keeps a sticky reset-cause register for software. It sits between the PLL/board pins and the SoC reset inputs (PORESETn, system resets).

---
 rtl/reset_seq.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/reset_seq.sv
// Reset sequencer: synchronises and debounces the board reset sources, then releases
// NUM_OUT active-low resets in order, with partial re-reset from SYSRESETREQ and a sticky cause register.
module reset_seq #(
  parameter int NUM_OUT         = 2,
  parameter int HOLD_CYCLES     = 255,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2,
  parameter bit BTN_ACTIVE_HIGH = 1'b1,
  parameter int SYSRST_FIRST    = 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               BTN,
  input  logic               PLL_LOCKED,
  input  logic               SYSRESETREQ,
  input  logic               CAUSE_CLR,
  output logic [NUM_OUT-1:0] RSTN_O,
  output logic               RST_DONE,
  output logic [3:0]         RST_CAUSE
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 2);
  localparam int GAP_W = $clog2(STAGE_GAP + 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int IDX_W = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic BTN_ON  = BTN_ACTIVE_HIGH;
  localparam logic BTN_OFF = !BTN_ACTIVE_HIGH;

  localparam logic [CNT_W-1:0]   HOLD_INIT = CNT_W'(HOLD_CYCLES);
  localparam logic [GAP_W-1:0]   GAP_INIT  = GAP_W'(STAGE_GAP - 1);
  localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0]   LAST      = IDX_W'(NUM_OUT - 1);
  localparam logic [IDX_W-1:0]   SYS_START = IDX_W'(SYSRST_FIRST);
  // Outputs below SYSRST_FIRST survive a system reset request.
  localparam logic [NUM_OUT-1:0] SYS_KEEP  = NUM_OUT'((64'd1 << SYSRST_FIRST) - 64'd1);

  localparam logic [1:0] ST_HOLD = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [SYNC_STAGES-1:0] pll_chain;
  logic [SYNC_STAGES-1:0] btn_chain;
  logic                   pll_sync;
  logic                   btn_sync;
  logic                   pll_fall;
  logic                   btn_db;
  logic [DEB_W-1:0]       deb_cnt;
  logic                   btn_diff;
  logic                   btn_rise;
  logic                   fr;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [GAP_W-1:0] gap;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;
  logic [IDX_W-1:0] start;
  logic             sys_act;

  assign pll_sync = pll_chain[SYNC_STAGES-1];
  assign btn_sync = btn_chain[SYNC_STAGES-1];
  assign pll_fall = pll_chain[SYNC_STAGES-1] & ~pll_chain[SYNC_STAGES-2];
  assign btn_diff = (btn_sync != btn_db);
  assign btn_rise = btn_diff && (deb_cnt == DEB_LAST) && (btn_sync == BTN_ON);
  assign fr       = (btn_db == BTN_ON) || !pll_sync;
  assign idx_next = idx + 1'b1;
  assign sys_act  = (state == ST_RUN) && SYSRESETREQ && !fr;

  // Synchronisers: PLL reads unlocked and BTN idle while in reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pll_chain <= '0;
      btn_chain <= {SYNC_STAGES{BTN_OFF}};
    end else begin
      pll_chain <= {pll_chain[SYNC_STAGES-2:0], PLL_LOCKED};
      btn_chain <= {btn_chain[SYNC_STAGES-2:0], BTN};
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      btn_db  <= BTN_OFF;
      deb_cnt <= '0;
    end else if (btn_diff) begin
      if (deb_cnt == DEB_LAST) begin
        btn_db  <= btn_sync;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end else begin
      deb_cnt <= '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_HOLD;
      cnt      <= HOLD_INIT;
      gap      <= '0;
      idx      <= '0;
      start    <= '0;
      RSTN_O   <= '0;
      RST_DONE <= 1'b0;
    end else if (fr) begin
      state    <= ST_HOLD;
      cnt      <= HOLD_INIT;
      start    <= '0;
      RSTN_O   <= '0;
      RST_DONE <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            RSTN_O[start] <= 1'b1;
            idx           <= start;
            gap           <= GAP_INIT;
            if (start == LAST) begin
              state    <= ST_RUN;
              RST_DONE <= 1'b1;
            end else begin
              state <= ST_STEP;
            end
          end
        end
        ST_STEP: begin
          if (gap != '0) begin
            gap <= gap - 1'b1;
          end else begin
            RSTN_O[idx_next] <= 1'b1;
            idx              <= idx_next;
            gap              <= GAP_INIT;
            if (idx_next == LAST) begin
              state    <= ST_RUN;
              RST_DONE <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (SYSRESETREQ) begin
            RSTN_O   <= RSTN_O & SYS_KEEP;
            RST_DONE <= 1'b0;
            state    <= ST_HOLD;
            cnt      <= HOLD_INIT;
            start    <= SYS_START;
          end
        end
        default: begin
          state <= ST_HOLD;
          cnt   <= HOLD_INIT;
          start <= '0;
        end
      endcase
    end
  end

  // A cause that sets in the same cycle as CAUSE_CLR survives the clear.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      RST_CAUSE <= 4'b0001;
    end else begin
      RST_CAUSE <= (CAUSE_CLR ? 4'b0000 : RST_CAUSE) | {sys_act, pll_fall, btn_rise, 1'b0};
    end
  end

endmodule
